// File: rtl/bin_to_bcd_seq.sv
// Sequential 16-bit binary to 5-digit packed BCD converter (double dabble, one bit per clock).
// The result is held stable between conversions so a display multiplexer can read it at any time.
module bin_to_bcd_seq #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [WIDTH-1:0]      bin,
  input  logic                  start,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            state_dbg
);

  // Handshake: start is level-sampled on every rising edge but only accepted in IDLE;
  // busy is high from the accepting edge until the block returns to IDLE, and done
  // pulses for exactly one cycle, coinciding with bcd/ovf taking their new value.

  localparam int BW = 4 * DIGITS;
  localparam int RW = BW + WIDTH;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state_q;
  logic [RW-1:0]   work_q;
  logic [RW-1:0]   work_d;
  logic [BW-1:0]   adj;
  logic [CW-1:0]   cnt_q;
  logic [BW-1:0]   bcd_q;
  logic            ovf_q;
  logic            busy_q;
  logic            done_q;

  // Add 3 to every nibble >= 5 independently, then shift the whole register left.
  always_comb begin
    adj = work_q[RW-1:WIDTH];
    for (int i = 0; i < DIGITS; i++) begin
      if (adj[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
      end
    end
    work_d = {adj[BW-2:0], work_q[WIDTH-1:0], 1'b0};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            work_q  <= {{BW{1'b0}}, bin};
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          work_q <= work_d;
          cnt_q  <= cnt_q + CW'(1);
          // The last shift publishes its own result so done appears on entry to DONE.
          if (cnt_q == LAST) begin
            bcd_q   <= work_d[RW-1:WIDTH];
            ovf_q   <= |work_d[RW-1:RW-4];
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bcd       = bcd_q;
  assign ovf       = ovf_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: directed vector table, multi-cycle corner sequences,
// and a random pass against a decimal-digit reference model.
module tb_bin_to_bcd_seq;

  logic        clock;
  logic        reset_n;
  logic [15:0] bin;
  logic        start;
  logic [19:0] bcd;
  logic        ovf;
  logic        busy;
  logic        done;
  logic [1:0]  state_dbg;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  typedef struct {
    logic [15:0] bin;
    logic [19:0] bcd;
    logic        ovf;
  } vec_t;

  vec_t vecs[15];

  bin_to_bcd_seq #(.WIDTH(16), .DIGITS(5)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .bin       (bin),
    .start     (start),
    .bcd       (bcd),
    .ovf       (ovf),
    .busy      (busy),
    .done      (done),
    .state_dbg (state_dbg)
  );

  // Clock and reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [19:0] ref_bcd(input int unsigned v);
    logic [19:0] r;
    int unsigned x;
    r = '0;
    x = v;
    for (int d = 0; d < 5; d++) begin
      r[4*d +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Run one conversion. ign_i > 0 re-pulses start with alt at that cycle of the conversion.
  task automatic conv(input string tag, input logic [15:0] v, input logic [19:0] exp_bcd,
                      input logic exp_ovf, input int ign_i, input logic [15:0] alt, input int tail);
    logic [19:0] prev;
    int lat, bcnt, dcnt;
    bit got, hold_err;
    prev = bcd;
    lat = 0; bcnt = 0; dcnt = 0; got = 0; hold_err = 0;
    @(negedge clock);
    bin   = v;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int i = 1; i <= 40 && !got; i++) begin
      if (busy) bcnt++;
      if (done) begin
        got = 1;
        lat = i;
        dcnt++;
      end else begin
        if (bcd !== prev) hold_err = 1;
        if (i == ign_i) begin
          start = 1'b1;
          bin   = alt;
        end else begin
          start = 1'b0;
        end
        @(negedge clock);
      end
    end
    start = 1'b0;
    check({tag, " done_seen"}, 32'(got), 32'd1);
    check({tag, " bcd"}, 32'(bcd), 32'(exp_bcd));
    check({tag, " ovf"}, 32'(ovf), 32'(exp_ovf));
    if (tail > 0) begin
      check({tag, " latency"}, 32'(lat), 32'd17);
      check({tag, " busy_cycles"}, 32'(bcnt), 32'd17);
      check({tag, " bcd_held"}, 32'(hold_err), 32'd0);
      for (int k = 0; k < tail; k++) begin
        @(negedge clock);
        if (done) dcnt++;
        if (k == 0) check({tag, " busy_after"}, 32'(busy), 32'd0);
      end
      check({tag, " single_done"}, 32'(dcnt), 32'd1);
    end
  endtask

  initial begin
    int n, got_n;
    int t[3];
    bit seen_bad;
    logic [15:0] rv;

    vecs[0]  = '{16'd20,    20'h00020, 1'b0};
    vecs[1]  = '{16'd9999,  20'h09999, 1'b0};
    vecs[2]  = '{16'd10000, 20'h10000, 1'b1};
    vecs[3]  = '{16'd65535, 20'h65535, 1'b1};
    vecs[4]  = '{16'd0,     20'h00000, 1'b0};
    vecs[5]  = '{16'd1,     20'h00001, 1'b0};
    vecs[6]  = '{16'd9,     20'h00009, 1'b0};
    vecs[7]  = '{16'd10,    20'h00010, 1'b0};
    vecs[8]  = '{16'd99,    20'h00099, 1'b0};
    vecs[9]  = '{16'd100,   20'h00100, 1'b0};
    vecs[10] = '{16'd4095,  20'h04095, 1'b0};
    vecs[11] = '{16'd12345, 20'h12345, 1'b1};
    vecs[12] = '{16'd59999, 20'h59999, 1'b1};
    vecs[13] = '{16'd32768, 20'h32768, 1'b1};
    vecs[14] = '{16'd1000,  20'h01000, 1'b0};

    reset_n = 1'b0;
    bin     = '0;
    start   = 1'b0;
    repeat (3) @(negedge clock);
    check("reset bcd", 32'(bcd), 32'h0);
    check("reset ovf", 32'(ovf), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    reset_n = 1'b1;
    @(negedge clock);

    for (int i = 0; i < 15; i++) begin
      conv($sformatf("vec%0d", i), vecs[i].bin, vecs[i].bcd, vecs[i].ovf, 0, 16'd0, 2);
    end

    // start re-pulsed mid-conversion is ignored
    conv("ignore", 16'd1234, 20'h01234, 1'b0, 5, 16'd4321, 20);
    conv("after_ignore", 16'd4321, 20'h04321, 1'b0, 0, 16'd0, 2);

    // Reset mid-conversion abandons it
    conv("pre_reset", 16'd20, 20'h00020, 1'b0, 0, 16'd0, 2);
    @(negedge clock);
    bin   = 16'd500;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (7) @(negedge clock);
    check("mid_reset prev_held", 32'(bcd), 32'h00020);
    reset_n = 1'b0;
    #1;
    check("mid_reset bcd", 32'(bcd), 32'h0);
    check("mid_reset busy", 32'(busy), 32'd0);
    check("mid_reset done", 32'(done), 32'd0);
    check("mid_reset ovf", 32'(ovf), 32'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    n = 0;
    seen_bad = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clock);
      if (done) n++;
      if (busy) seen_bad = 1;
    end
    check("mid_reset no_done", 32'(n), 32'd0);
    check("mid_reset stays_idle", 32'(seen_bad), 32'd0);
    conv("post_reset", 16'd500, 20'h00500, 1'b0, 0, 16'd0, 2);

    // start held high: one result every 18 clocks
    @(negedge clock);
    bin   = 16'd7;
    start = 1'b1;
    n = 0;
    got_n = 0;
    seen_bad = 0;
    while (got_n < 3 && n < 100) begin
      @(negedge clock);
      n++;
      if (done) begin
        t[got_n] = n;
        got_n++;
        if (bcd !== 20'h00007) seen_bad = 1;
      end
    end
    start = 1'b0;
    check("held done_count", 32'(got_n), 32'd3);
    check("held bcd", 32'(seen_bad), 32'd0);
    if (got_n == 3) begin
      check("held period1", 32'(t[1] - t[0]), 32'd18);
      check("held period2", 32'(t[2] - t[1]), 32'd18);
    end
    repeat (3) @(negedge clock);

    // Random pass against decimal reference model
    for (int i = 0; i < 1000; i++) begin
      rv = 16'($urandom_range(0, 65535));
      conv($sformatf("rand%0d(%0d)", i, rv), rv, ref_bcd(rv), (rv > 16'd9999), 0, 16'd0, 0);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
